// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, instruction-type codes and constants for the integer execute unit.
// Type codes match what the decoder writes into the reservation station's type field.
package alu_exec_unit_pkg;

    localparam int ALU_DATA_W    = 32;
    localparam int ALU_ADDR_W    = 32;
    localparam int ALU_ROB_W     = 4;
    localparam int ALU_TYPE_W    = 6;
    localparam int ALU_BUF_DEPTH = 2;

    localparam logic [ALU_DATA_W-1:0] DATA_ZERO = '0;
    localparam logic [ALU_ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ALU_ROB_W-1:0]  ROB_ZERO  = '0;

    // Codes 30..63 belong to loads/stores or are unused; this unit treats them as no-ops.
    typedef enum logic [ALU_TYPE_W-1:0] {
        T_NOP   = 6'd0,
        T_LUI   = 6'd1,
        T_AUIPC = 6'd2,
        T_JAL   = 6'd3,
        T_JALR  = 6'd4,
        T_BEQ   = 6'd5,
        T_BNE   = 6'd6,
        T_BLT   = 6'd7,
        T_BGE   = 6'd8,
        T_BLTU  = 6'd9,
        T_BGEU  = 6'd10,
        T_ADDI  = 6'd11,
        T_SLTI  = 6'd12,
        T_SLTIU = 6'd13,
        T_XORI  = 6'd14,
        T_ORI   = 6'd15,
        T_ANDI  = 6'd16,
        T_SLLI  = 6'd17,
        T_SRLI  = 6'd18,
        T_SRAI  = 6'd19,
        T_ADD   = 6'd20,
        T_SUB   = 6'd21,
        T_SLL   = 6'd22,
        T_SLT   = 6'd23,
        T_SLTU  = 6'd24,
        T_XOR   = 6'd25,
        T_SRL   = 6'd26,
        T_SRA   = 6'd27,
        T_OR    = 6'd28,
        T_AND   = 6'd29
    } ins_type_e;

    // Second operand comes from the immediate for these types.
    function automatic logic is_imm_op(input logic [ALU_TYPE_W-1:0] t);
        return (t >= T_ADDI && t <= T_SRAI) ||
               (t == T_LUI) || (t == T_AUIPC) || (t == T_JAL) || (t == T_JALR);
    endfunction

endpackage

// File: rtl/alu_exec_unit_compute.sv
// Purely combinational evaluation of one issued instruction: rd value, taken flag
// and next PC.
module alu_compute
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int ADDR_W = ALU_ADDR_W,
    parameter int TYPE_W = ALU_TYPE_W
) (
    input  logic [TYPE_W-1:0] i_ins_type,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_value,
    output logic              o_jump,
    output logic [ADDR_W-1:0] o_target
);

    logic [DATA_W-1:0] w_op_b;
    logic [4:0]        w_shamt;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_rel;
    logic [ADDR_W-1:0] w_jalr_sum;
    logic              w_eq;
    logic              w_lt;
    logic              w_ltu;

    assign w_op_b     = is_imm_op(i_ins_type) ? i_imm : i_rs2;
    assign w_shamt    = w_op_b[4:0];
    assign w_pc_plus4 = i_pc + ADDR_W'(4);
    assign w_pc_rel   = i_pc + ADDR_W'(i_imm);
    assign w_jalr_sum = ADDR_W'(i_rs1 + i_imm);
    assign w_eq       = (i_rs1 == w_op_b);
    assign w_lt       = ($signed(i_rs1) < $signed(w_op_b));
    assign w_ltu      = (i_rs1 < w_op_b);

    always_comb begin
        o_value  = '0;
        o_jump   = 1'b0;
        o_target = w_pc_plus4;
        case (i_ins_type)
            T_ADD,  T_ADDI:  o_value = i_rs1 + w_op_b;
            T_SUB:           o_value = i_rs1 - w_op_b;
            T_AND,  T_ANDI:  o_value = i_rs1 & w_op_b;
            T_OR,   T_ORI:   o_value = i_rs1 | w_op_b;
            T_XOR,  T_XORI:  o_value = i_rs1 ^ w_op_b;
            T_SLL,  T_SLLI:  o_value = i_rs1 << w_shamt;
            T_SRL,  T_SRLI:  o_value = i_rs1 >> w_shamt;
            T_SRA,  T_SRAI:  o_value = DATA_W'($signed(i_rs1) >>> w_shamt);
            T_SLT,  T_SLTI:  o_value = {{(DATA_W-1){1'b0}}, w_lt};
            T_SLTU, T_SLTIU: o_value = {{(DATA_W-1){1'b0}}, w_ltu};
            T_LUI:           o_value = i_imm;
            T_AUIPC:         o_value = DATA_W'(w_pc_rel);
            T_JAL: begin
                o_value  = DATA_W'(w_pc_plus4);
                o_jump   = 1'b1;
                o_target = w_pc_rel;
            end
            T_JALR: begin
                o_value  = DATA_W'(w_pc_plus4);
                o_jump   = 1'b1;
                o_target = {w_jalr_sum[ADDR_W-1:1], 1'b0};
            end
            T_BEQ:  o_jump = w_eq;
            T_BNE:  o_jump = !w_eq;
            T_BLT:  o_jump = w_lt;
            T_BGE:  o_jump = !w_lt;
            T_BLTU: o_jump = w_ltu;
            T_BGEU: o_jump = !w_ltu;
            default: ;
        endcase
        // Only branches can still be taken here; JAL/JALR already set their target.
        if (o_jump && i_ins_type >= T_BEQ && i_ins_type <= T_BGEU) begin
            o_target = w_pc_rel;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute unit: evaluates an issued instruction in the issue cycle and holds results in a
// small circular buffer until the CDB grants the bus, then broadcasts the head entry.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W    = ALU_DATA_W,
    parameter int ADDR_W    = ALU_ADDR_W,
    parameter int ROB_W     = ALU_ROB_W,
    parameter int TYPE_W    = ALU_TYPE_W,
    parameter int BUF_DEPTH = ALU_BUF_DEPTH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob2alu_flush,
    input  logic              rs2alu_enable,
    input  logic [DATA_W-1:0] rs2alu_rs1,
    input  logic [DATA_W-1:0] rs2alu_rs2,
    input  logic [DATA_W-1:0] rs2alu_imm,
    input  logic [TYPE_W-1:0] rs2alu_ins_type,
    input  logic [ADDR_W-1:0] rs2alu_pc,
    input  logic [ROB_W-1:0]  rs2alu_reorder,
    output logic              alu_full,
    input  logic              cdb2alu_grant,
    output logic              alu2rs_bypass_enable,
    output logic [ROB_W-1:0]  alu2rs_bypass_reorder,
    output logic [DATA_W-1:0] alu2rs_bypass_value,
    output logic              alu2rob_jump,
    output logic [ADDR_W-1:0] alu2rob_target_pc
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ROB_W-1:0]  r_tag    [BUF_DEPTH];
    logic [DATA_W-1:0] r_value  [BUF_DEPTH];
    logic              r_jump   [BUF_DEPTH];
    logic [ADDR_W-1:0] r_target [BUF_DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_valid;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_value;
    logic              w_jump;
    logic [ADDR_W-1:0] w_target;

    alu_compute #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TYPE_W (TYPE_W)
    ) u_compute (
        .i_ins_type (rs2alu_ins_type),
        .i_rs1      (rs2alu_rs1),
        .i_rs2      (rs2alu_rs2),
        .i_imm      (rs2alu_imm),
        .i_pc       (rs2alu_pc),
        .o_value    (w_value),
        .o_jump     (w_jump),
        .o_target   (w_target)
    );

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_FULL);

    // Flush wins over both sides of the handshake; a full buffer still accepts an
    // issue in the same cycle its head drains.
    assign w_pop  = rdy_in && !rob2alu_flush && w_valid && cdb2alu_grant;
    assign w_push = rdy_in && !rob2alu_flush && rs2alu_enable && (!w_full || w_pop);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (rob2alu_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end

    // Payload storage needs no reset: it is only observed while the count says valid.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_tag[r_tail]    <= rs2alu_reorder;
            r_value[r_tail]  <= w_value;
            r_jump[r_tail]   <= w_jump;
            r_target[r_tail] <= w_target;
        end
    end

    assign alu_full              = w_full;
    assign alu2rs_bypass_enable  = w_valid;
    assign alu2rs_bypass_reorder = w_valid ? r_tag[r_head]    : '0;
    assign alu2rs_bypass_value   = w_valid ? r_value[r_head]  : '0;
    assign alu2rob_jump          = w_valid ? r_jump[r_head]   : 1'b0;
    assign alu2rob_target_pc     = w_valid ? r_target[r_head] : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios with literal expectations plus a long
// randomized run checked every cycle against a queue-based reference model.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int DEPTH = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob2alu_flush;
    logic        rs2alu_enable;
    logic [31:0] rs2alu_rs1;
    logic [31:0] rs2alu_rs2;
    logic [31:0] rs2alu_imm;
    logic [5:0]  rs2alu_ins_type;
    logic [31:0] rs2alu_pc;
    logic [3:0]  rs2alu_reorder;
    logic        alu_full;
    logic        cdb2alu_grant;
    logic        alu2rs_bypass_enable;
    logic [3:0]  alu2rs_bypass_reorder;
    logic [31:0] alu2rs_bypass_value;
    logic        alu2rob_jump;
    logic [31:0] alu2rob_target_pc;

    alu_exec_unit dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .rdy_in                (rdy_in),
        .rob2alu_flush         (rob2alu_flush),
        .rs2alu_enable         (rs2alu_enable),
        .rs2alu_rs1            (rs2alu_rs1),
        .rs2alu_rs2            (rs2alu_rs2),
        .rs2alu_imm            (rs2alu_imm),
        .rs2alu_ins_type       (rs2alu_ins_type),
        .rs2alu_pc             (rs2alu_pc),
        .rs2alu_reorder        (rs2alu_reorder),
        .alu_full              (alu_full),
        .cdb2alu_grant         (cdb2alu_grant),
        .alu2rs_bypass_enable  (alu2rs_bypass_enable),
        .alu2rs_bypass_reorder (alu2rs_bypass_reorder),
        .alu2rs_bypass_value   (alu2rs_bypass_value),
        .alu2rob_jump          (alu2rob_jump),
        .alu2rob_target_pc     (alu2rob_target_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        jump;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_pop;
    bit   m_push;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one instruction, written directly from the ISA rules.
    function automatic ent_t golden(input logic [5:0] t, input logic [31:0] a,
                                    input logic [31:0] r2, input logic [31:0] im,
                                    input logic [31:0] p, input logic [3:0] tag);
        ent_t e;
        logic [31:0] b;
        int   sh;
        logic take;
        logic is_br;
        b = (t inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_ADDI, T_SLTI, T_SLTIU,
                       T_XORI, T_ORI, T_ANDI, T_SLLI, T_SRLI, T_SRAI}) ? im : r2;
        sh = int'(b % 32);
        e.tag = tag; e.val = 32'd0; e.jump = 1'b0; e.tgt = p + 32'd4;
        take = 1'b0; is_br = 1'b0;
        case (t)
            T_ADD, T_ADDI:   e.val = a + b;
            T_SUB:           e.val = a - b;
            T_AND, T_ANDI:   e.val = a & b;
            T_OR, T_ORI:     e.val = a | b;
            T_XOR, T_XORI:   e.val = a ^ b;
            T_SLL, T_SLLI:   e.val = a << sh;
            T_SRL, T_SRLI:   e.val = a >> sh;
            T_SRA, T_SRAI:   e.val = 32'($signed(a) >>> sh);
            T_SLT, T_SLTI:   e.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            T_SLTU, T_SLTIU: e.val = (a < b) ? 32'd1 : 32'd0;
            T_LUI:           e.val = im;
            T_AUIPC:         e.val = p + im;
            T_JAL:  begin e.val = p + 32'd4; e.jump = 1'b1; e.tgt = p + im; end
            T_JALR: begin e.val = p + 32'd4; e.jump = 1'b1; e.tgt = (a + im) & 32'hFFFF_FFFE; end
            T_BEQ:  begin is_br = 1'b1; take = (a == b); end
            T_BNE:  begin is_br = 1'b1; take = (a != b); end
            T_BLT:  begin is_br = 1'b1; take = ($signed(a) < $signed(b)); end
            T_BGE:  begin is_br = 1'b1; take = ($signed(a) >= $signed(b)); end
            T_BLTU: begin is_br = 1'b1; take = (a < b); end
            T_BGEU: begin is_br = 1'b1; take = (a >= b); end
            default: ;
        endcase
        if (is_br) begin
            e.jump = take;
            e.tgt  = take ? p + im : p + 32'd4;
        end
        return e;
    endfunction

    // Buffer model: a plain FIFO of expected broadcasts.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            q.delete();
        end else if (rdy_in) begin
            if (rob2alu_flush) begin
                q.delete();
            end else begin
                m_pop  = (q.size() != 0) && cdb2alu_grant;
                m_push = rs2alu_enable && (q.size() < DEPTH || m_pop);
                if (rs2alu_enable && !m_push) begin
                    n_fail++;
                    $display("FAIL protocol: issue while full without grant at t=%0t", $time);
                end
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(golden(rs2alu_ins_type, rs2alu_rs1, rs2alu_rs2,
                                               rs2alu_imm, rs2alu_pc, rs2alu_reorder));
            end
        end
    end

    always @(negedge clk_in) begin
        check("model_enable", 32'(alu2rs_bypass_enable), 32'(q.size() != 0));
        check("model_full",   32'(alu_full),             32'(q.size() == DEPTH));
        if (q.size() != 0) begin
            check("model_tag",    32'(alu2rs_bypass_reorder), 32'(q[0].tag));
            check("model_value",  alu2rs_bypass_value,        q[0].val);
            check("model_jump",   32'(alu2rob_jump),          32'(q[0].jump));
            check("model_target", alu2rob_target_pc,          q[0].tgt);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic [3:0] tag);
        rs2alu_enable   = 1'b1;
        rs2alu_ins_type = t;
        rs2alu_rs1      = a;
        rs2alu_rs2      = b;
        rs2alu_imm      = im;
        rs2alu_pc       = p;
        rs2alu_reorder  = tag;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_enable"}, 32'(alu2rs_bypass_enable),  32'd0);
        check({tag, "_full"},   32'(alu_full),              32'd0);
        check({tag, "_tag"},    32'(alu2rs_bypass_reorder), 32'd0);
        check({tag, "_value"},  alu2rs_bypass_value,        32'd0);
        check({tag, "_jump"},   32'(alu2rob_jump),          32'd0);
        check({tag, "_target"}, alu2rob_target_pc,          32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom % 5)
            0: return 32'($urandom_range(0, 40));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob2alu_flush = 1'b0; cdb2alu_grant = 1'b0;
        drive(6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        rs2alu_enable = 1'b0;
        #2;
        check_zero_outputs("reset");
        #21 rst_in = 1'b0;
        step();

        // ADD with grant held: one cycle of broadcast, then empty.
        cdb2alu_grant = 1'b1;
        drive(T_ADD, 32'd5, 32'd7, 32'd0, 32'h0, 4'd3);
        step();
        rs2alu_enable = 1'b0;
        check("add_enable", 32'(alu2rs_bypass_enable), 32'd1);
        check("add_tag",    32'(alu2rs_bypass_reorder), 32'd3);
        check("add_value",  alu2rs_bypass_value, 32'd12);
        check("add_jump",   32'(alu2rob_jump), 32'd0);
        step();
        check("add_drained", 32'(alu2rs_bypass_enable), 32'd0);

        // Signed vs unsigned less-than on the same operands, back to back.
        drive(T_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd1);
        step();
        drive(T_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd2);
        check("blt_jump",   32'(alu2rob_jump), 32'd1);
        check("blt_target", alu2rob_target_pc, 32'h120);
        check("blt_value",  alu2rs_bypass_value, 32'd0);
        step();
        rs2alu_enable = 1'b0;
        check("bltu_tag",    32'(alu2rs_bypass_reorder), 32'd2);
        check("bltu_jump",   32'(alu2rob_jump), 32'd0);
        check("bltu_target", alu2rob_target_pc, 32'h104);
        step();

        drive(T_JALR, 32'h1003, 32'd0, 32'd4, 32'h40, 4'd4);
        step();
        rs2alu_enable = 1'b0;
        check("jalr_value",  alu2rs_bypass_value, 32'h44);
        check("jalr_jump",   32'(alu2rob_jump), 32'd1);
        check("jalr_target", alu2rob_target_pc, 32'h1006);
        step();

        // Fill with grant low, then push and pop together at full.
        cdb2alu_grant = 1'b0;
        drive(T_ADD, 32'd1, 32'd1, 32'd0, 32'h200, 4'd1);
        step();
        drive(T_ADD, 32'd2, 32'd2, 32'd0, 32'h204, 4'd2);
        step();
        rs2alu_enable = 1'b0;
        check("fill_full", 32'(alu_full), 32'd1);
        check("fill_head", 32'(alu2rs_bypass_reorder), 32'd1);
        step();
        check("hold_head", 32'(alu2rs_bypass_reorder), 32'd1);
        drive(T_ADD, 32'd3, 32'd3, 32'd0, 32'h208, 4'd3);
        cdb2alu_grant = 1'b1;
        step();
        rs2alu_enable = 1'b0;
        check("order_2",      32'(alu2rs_bypass_reorder), 32'd2);
        check("order_2_full", 32'(alu_full), 32'd1);
        step();
        check("order_3",       32'(alu2rs_bypass_reorder), 32'd3);
        check("order_3_value", alu2rs_bypass_value, 32'd6);
        check("order_3_full",  32'(alu_full), 32'd0);
        step();
        check("order_empty", 32'(alu2rs_bypass_enable), 32'd0);

        // Flush with two entries buffered and a concurrent issue and grant.
        cdb2alu_grant = 1'b0;
        drive(T_OR, 32'hF0, 32'h0F, 32'd0, 32'h300, 4'd7);
        step();
        drive(T_OR, 32'hF1, 32'h0F, 32'd0, 32'h304, 4'd8);
        step();
        check("preflush_full", 32'(alu_full), 32'd1);
        rob2alu_flush = 1'b1;
        cdb2alu_grant = 1'b1;
        drive(T_ADD, 32'd9, 32'd9, 32'd0, 32'h308, 4'd9);
        step();
        rob2alu_flush = 1'b0; rs2alu_enable = 1'b0; cdb2alu_grant = 1'b0;
        check("flush_enable", 32'(alu2rs_bypass_enable), 32'd0);
        check("flush_full",   32'(alu_full), 32'd0);
        drive(T_ADD, 32'd2, 32'd3, 32'd0, 32'h30C, 4'd5);
        step();
        rs2alu_enable = 1'b0;
        check("postflush_tag",   32'(alu2rs_bypass_reorder), 32'd5);
        check("postflush_value", alu2rs_bypass_value, 32'd5);
        cdb2alu_grant = 1'b1;
        step();
        cdb2alu_grant = 1'b0;
        check("postflush_drained", 32'(alu2rs_bypass_enable), 32'd0);

        // Asynchronous reset between edges while a result is on the bus.
        drive(T_XOR, 32'hF0, 32'h0F, 32'd0, 32'h400, 4'd6);
        step();
        rs2alu_enable = 1'b0;
        check("prereset_tag", 32'(alu2rs_bypass_reorder), 32'd6);
        #3 rst_in = 1'b1;
        #1 check_zero_outputs("async_reset");
        #2 rst_in = 1'b0;
        step();

        // rdy_in low freezes the head even with grant high.
        drive(T_SUB, 32'd10, 32'd3, 32'd0, 32'h500, 4'd4);
        step();
        rs2alu_enable = 1'b0;
        check("rdy_pre_value", alu2rs_bypass_value, 32'd7);
        rdy_in = 1'b0;
        cdb2alu_grant = 1'b1;
        step();
        check("rdy_hold_enable", 32'(alu2rs_bypass_enable), 32'd1);
        check("rdy_hold_tag",    32'(alu2rs_bypass_reorder), 32'd4);
        step();
        check("rdy_hold_value", alu2rs_bypass_value, 32'd7);
        rdy_in = 1'b1;
        step();
        cdb2alu_grant = 1'b0;
        check("rdy_release", 32'(alu2rs_bypass_enable), 32'd0);

        // Randomized traffic; the compare process checks every cycle.
        repeat (3000) begin
            rdy_in        = ($urandom % 8) != 0;
            rob2alu_flush = ($urandom % 40) == 0;
            cdb2alu_grant = ($urandom % 3) != 0;
            if ((($urandom % 4) != 0) && (q.size() < DEPTH || cdb2alu_grant)) begin
                drive(6'($urandom_range(0, 35)), rnd_operand(), rnd_operand(), rnd_operand(),
                      $urandom & 32'hFFFF_FFFC, 4'($urandom));
                if (($urandom % 4) == 0) rs2alu_rs2 = rs2alu_rs1;
            end else begin
                rs2alu_enable = 1'b0;
            end
            step();
        end

        rs2alu_enable = 1'b0; rdy_in = 1'b1; rob2alu_flush = 1'b0; cdb2alu_grant = 1'b1;
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
